// File: rtl/axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_wr_arbiter
//   Two-requester arbiter in front of a single AXI write master. Only one
//   write is in flight at a time: IDLE -> ISSUE -> WAIT_RESP -> IDLE.
//
//   Build option: define AXI_WARB_RR_EN for round-robin arbitration (the
//   last winner loses a tie). Without it, requester 0 always wins a tie.
//
//   Ports
//     ACLK, ARESETn          clock, synchronous active-low reset
//     sN_wen / sN_* payload  write request from requester N (N = 0,1)
//     sN_waddr_ok            1-cycle pulse: master accepted N's request
//     sN_wdata_ok            1-cycle pulse: write response for N received
//     m_wen / m_* payload    request to the write master
//     m_data_resp            high while waiting for the write response
//     m_waddr_ok, m_wdata_ok pulses from the write master
//     busy                   FSM not idle
//     grant                  index of the current owner
//     timeout_err            1-cycle pulse when the response is late
// ---------------------------------------------------------------------------
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module axi_wr_arbiter #(
   parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
   parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
   parameter int ID_WIDTH   = `AXI_ID_WIDTH,
   parameter int TIMEOUT    = 255
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic                  s0_wen,
   input  logic [3:0]            s0_wmask,
   input  logic [2:0]            s0_awsize,
   input  logic [ADDR_WIDTH-1:0] s0_awaddr,
   input  logic [DATA_WIDTH-1:0] s0_wdata,
   input  logic [ID_WIDTH-1:0]   s0_awid,
   output logic                  s0_waddr_ok,
   output logic                  s0_wdata_ok,
   input  logic                  s1_wen,
   input  logic [3:0]            s1_wmask,
   input  logic [2:0]            s1_awsize,
   input  logic [ADDR_WIDTH-1:0] s1_awaddr,
   input  logic [DATA_WIDTH-1:0] s1_wdata,
   input  logic [ID_WIDTH-1:0]   s1_awid,
   output logic                  s1_waddr_ok,
   output logic                  s1_wdata_ok,
   output logic                  m_wen,
   output logic [3:0]            m_wmask,
   output logic [2:0]            m_awsize,
   output logic [ADDR_WIDTH-1:0] m_awaddr,
   output logic [DATA_WIDTH-1:0] m_wdata,
   output logic [ID_WIDTH-1:0]   m_awid,
   output logic                  m_data_resp,
   input  logic                  m_waddr_ok,
   input  logic                  m_wdata_ok,
   output logic                  busy,
   output logic                  grant,
   output logic                  timeout_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

   // Counter holds the number of completed WAIT_RESP cycles, so the pulse
   // lands on the TIMEOUT-th cycle spent waiting.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t                state, state_nxt;
   logic                  win, grant_nxt;
   logic                  wen_nxt;
   logic [3:0]            wmask_nxt;
   logic [2:0]            awsize_nxt;
   logic [ADDR_WIDTH-1:0] awaddr_nxt;
   logic [DATA_WIDTH-1:0] wdata_nxt;
   logic [ID_WIDTH-1:0]   awid_nxt;
   logic [1:0]            waddr_ok_r, waddr_ok_nxt;
   logic [1:0]            wdata_ok_r, wdata_ok_nxt;
   logic [15:0]           cnt, cnt_nxt;
   logic                  tmo_nxt;

`ifdef AXI_WARB_RR_EN
   // Last winner; reset value 1 makes requester 0 win the first tie.
   logic rr_last, rr_last_nxt;
   assign win = (s0_wen && s1_wen) ? ~rr_last : ~s0_wen;
`else
   assign win = ~s0_wen;
`endif

   assign s0_waddr_ok = waddr_ok_r[0];
   assign s1_waddr_ok = waddr_ok_r[1];
   assign s0_wdata_ok = wdata_ok_r[0];
   assign s1_wdata_ok = wdata_ok_r[1];
   assign m_data_resp = (state == WAIT_RESP);
   assign busy        = (state != IDLE);

   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      wen_nxt      = m_wen;
      wmask_nxt    = m_wmask;
      awsize_nxt   = m_awsize;
      awaddr_nxt   = m_awaddr;
      wdata_nxt    = m_wdata;
      awid_nxt     = m_awid;
      waddr_ok_nxt = '0;
      wdata_ok_nxt = '0;
      cnt_nxt      = cnt;
      tmo_nxt      = 1'b0;
`ifdef AXI_WARB_RR_EN
      rr_last_nxt  = rr_last;
`endif
      unique case (state)
         IDLE: begin
            if (s0_wen || s1_wen) begin
               state_nxt  = ISSUE;
               grant_nxt  = win;
               wen_nxt    = 1'b1;
               wmask_nxt  = win ? s1_wmask  : s0_wmask;
               awsize_nxt = win ? s1_awsize : s0_awsize;
               awaddr_nxt = win ? s1_awaddr : s0_awaddr;
               wdata_nxt  = win ? s1_wdata  : s0_wdata;
               awid_nxt   = win ? s1_awid   : s0_awid;
`ifdef AXI_WARB_RR_EN
               rr_last_nxt = win;
`endif
            end
         end
         ISSUE: begin
            if (m_waddr_ok) begin
               state_nxt           = WAIT_RESP;
               wen_nxt             = 1'b0;
               wmask_nxt           = '0;
               awsize_nxt          = '0;
               awaddr_nxt          = '0;
               wdata_nxt           = '0;
               awid_nxt            = '0;
               waddr_ok_nxt[grant] = 1'b1;
               cnt_nxt             = '0;
               tmo_nxt             = (TMO_LAST == 16'd0);
            end
         end
         WAIT_RESP: begin
            if (m_wdata_ok) begin
               state_nxt           = IDLE;
               wdata_ok_nxt[grant] = 1'b1;
            end else if (cnt != 16'hFFFF) begin
               // Saturation stops the compare from matching a second time.
               cnt_nxt = cnt + 16'd1;
               tmo_nxt = (cnt_nxt == TMO_LAST);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state       <= IDLE;
         grant       <= 1'b0;
         m_wen       <= 1'b0;
         m_wmask     <= '0;
         m_awsize    <= '0;
         m_awaddr    <= '0;
         m_wdata     <= '0;
         m_awid      <= '0;
         waddr_ok_r  <= '0;
         wdata_ok_r  <= '0;
         cnt         <= '0;
         timeout_err <= 1'b0;
`ifdef AXI_WARB_RR_EN
         rr_last     <= 1'b1;
`endif
      end else begin
         state       <= state_nxt;
         grant       <= grant_nxt;
         m_wen       <= wen_nxt;
         m_wmask     <= wmask_nxt;
         m_awsize    <= awsize_nxt;
         m_awaddr    <= awaddr_nxt;
         m_wdata     <= wdata_nxt;
         m_awid      <= awid_nxt;
         waddr_ok_r  <= waddr_ok_nxt;
         wdata_ok_r  <= wdata_ok_nxt;
         cnt         <= cnt_nxt;
         timeout_err <= tmo_nxt;
`ifdef AXI_WARB_RR_EN
         rr_last     <= rr_last_nxt;
`endif
      end
   end

endmodule

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default `AXI_ADDR_WIDTH, meaning write address width.
REQ-002 SHALL have parameter DATA_WIDTH, default `AXI_DATA_WIDTH, meaning write data width.
REQ-003 SHALL have parameter ID_WIDTH, default `AXI_ID_WIDTH, meaning AWID width.
REQ-004 SHALL have parameter TIMEOUT, default 255, meaning response-wait cycles before timeout_err (1..65535).
REQ-005 SHALL have port ACLK  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port ARESETn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have ports sN_wen  input  1  write request from requester N, N in {0,1}.
REQ-008 SHALL have ports sN_wmask  input  4, sN_awsize  input  3, sN_awaddr  input  ADDR_WIDTH, sN_wdata  input  DATA_WIDTH, sN_awid  input  ID_WIDTH  request payload.
REQ-009 SHALL have ports sN_waddr_ok  output  1  one-cycle pulse: request accepted by write master.
REQ-010 SHALL have ports sN_wdata_ok  output  1  one-cycle pulse: write response received.
REQ-011 SHALL have ports m_wen  output  1, m_wmask  output  4, m_awsize  output  3, m_awaddr  output  ADDR_WIDTH, m_wdata  output  DATA_WIDTH, m_awid  output  ID_WIDTH  request to write master.
REQ-012 SHALL have port m_data_resp  output  1  response-ready to write master.
REQ-013 SHALL have ports m_waddr_ok  input  1, m_wdata_ok  input  1  pulses from write master.
REQ-014 SHALL have ports busy  output  1  state != IDLE; grant  output  1  index of current owner; timeout_err  output  1  one-cycle pulse.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WAIT_RESP -> IDLE; one outstanding write total.
REQ-016 In IDLE with any sN_wen=1, SHALL select a winner per REQ-027, register grant, latch winner payload onto m_* and set m_wen=1 next cycle, entering ISSUE.
REQ-017 In ISSUE, m_wen and m_* payload SHALL stay constant until m_waddr_ok=1.
REQ-018 On m_waddr_ok=1 in ISSUE: m_wen<=0, m_* payload<=0, sG_waddr_ok pulses next cycle for grant G only, enter WAIT_RESP.
REQ-019 m_data_resp SHALL be 1 exactly while in WAIT_RESP; m_wen SHALL be 0 in WAIT_RESP (prevents master back-to-back restart).
REQ-020 On m_wdata_ok=1 in WAIT_RESP: sG_wdata_ok pulses next cycle, enter IDLE; new arbitration earliest the cycle after return to IDLE.
REQ-021 A 16-bit counter SHALL clear on WAIT_RESP entry, increment each WAIT_RESP cycle, saturate; reaching TIMEOUT SHALL pulse timeout_err once; FSM keeps waiting (no abort).
REQ-022 Requester SHALL hold sN_wen and payload until its sN_waddr_ok; sN_wen from the non-granted requester SHALL be ignored until IDLE.
REQ-023 m_waddr_ok or m_wdata_ok arriving in a state that does not expect it SHALL be ignored.
REQ-024 sN_waddr_ok and sN_wdata_ok SHALL never be asserted for the non-granted requester.

Reset
REQ-025 On ARESETn=0 at a clock edge: state IDLE, all outputs 0, counter 0, round-robin pointer favouring requester 0.
REQ-026 Reset mid-transaction SHALL abandon the outstanding write with no ok pulses emitted.

Configuration
REQ-027 Macro AXI_WARB_RR_EN: defined -> round-robin, last winner gets lowest priority on simultaneous requests; undefined -> fixed priority, requester 0 always wins ties.
REQ-028 Without AXI_WARB_RR_EN the round-robin pointer SHALL not exist; single-requester behaviour SHALL be identical in both builds.

Verification
REQ-029 s0_wen=1, awaddr=0x1000, wdata=0xDEADBEEF, wmask=4'hF; master waddr_ok after 2 cycles, wdata_ok after 5 -> m_awaddr=0x1000, one s0_waddr_ok, one s0_wdata_ok, busy low after.
REQ-030 s0_wen and s1_wen rise same cycle, three times back-to-back -> RR build grants 0,1,0; fixed build grants 0,0,0 with s1 starved until s0_wen drops.
REQ-031 s1 requests while s0 in WAIT_RESP -> s1 granted only after s0_wdata_ok; m_wen=0 throughout WAIT_RESP.
REQ-032 TIMEOUT=8, withhold m_wdata_ok 20 cycles -> timeout_err single pulse on 8th WAIT_RESP cycle; later wdata_ok still completes.
REQ-033 ARESETn=0 during WAIT_RESP -> next cycle all outputs 0, no sN_wdata_ok; new request after reset completes normally.
REQ-034 Spurious m_wdata_ok in IDLE and m_waddr_ok in WAIT_RESP -> no state change, no ok pulses.
